// File: rtl/i2c_master_seq.sv
// Two-requester I2C write controller: round-robin grant, then one
// START / address+W / ACK / data / ACK / STOP sequence on an open-drain bus.
module i2c_master_seq #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_ACK1  = 3'd3,
        S_DATA  = 3'd4,
        S_ACK2  = 3'd5,
        S_STOP  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   div_r;
    logic [1:0]      q_r;
    logic [2:0]      bit_r;
    logic [6:0]      addr_r;
    logic [7:0]      data_r;
    logic            sel_r;
    logic            last_r;
    logic            flag_r;

    state_t          state_nx_s;
    logic [DW-1:0]   div_nx_s;
    logic [1:0]      q_nx_s;
    logic [2:0]      bit_nx_s;
    logic            tick_s;
    logic            slot_end_s;
    logic            any_req_s;
    logic            win1_s;
    logic [7:0]      tx_byte_s;
    logic            scl_nx_s;
    logic            sda_nx_s;

    // Round-robin arbitration: last_r=1 means requester 1 was served last.
    always_comb begin
        any_req_s = req0 | req1;
        if (req0 && req1) begin
            win1_s = ~last_r;
        end else if (req1) begin
            win1_s = 1'b1;
        end else begin
            win1_s = 1'b0;
        end
    end

    // Next bus position (state, slot bit, quarter, divider).
    always_comb begin
        tick_s     = (div_r == DIV_LAST);
        slot_end_s = tick_s && (q_r == 2'd3);
        state_nx_s = state_r;
        div_nx_s   = tick_s ? {DW{1'b0}} : div_r + DW'(1);
        q_nx_s     = tick_s ? q_r + 2'd1 : q_r;
        bit_nx_s   = bit_r;
        if (state_r == S_IDLE) begin
            div_nx_s   = {DW{1'b0}};
            q_nx_s     = 2'd0;
            bit_nx_s   = 3'd0;
            state_nx_s = any_req_s ? S_START : S_IDLE;
        end else if (state_r == S_DONE) begin
            div_nx_s   = {DW{1'b0}};
            q_nx_s     = 2'd0;
            bit_nx_s   = 3'd0;
            state_nx_s = S_IDLE;
        end else if (slot_end_s) begin
            case (state_r)
                S_START: begin
                    state_nx_s = S_ADDR;
                    bit_nx_s   = 3'd0;
                end
                S_ADDR: begin
                    state_nx_s = (bit_r == 3'd7) ? S_ACK1 : S_ADDR;
                    bit_nx_s   = (bit_r == 3'd7) ? 3'd0 : bit_r + 3'd1;
                end
                S_ACK1: begin
                    state_nx_s = flag_r ? S_STOP : S_DATA;
                    bit_nx_s   = 3'd0;
                end
                S_DATA: begin
                    state_nx_s = (bit_r == 3'd7) ? S_ACK2 : S_DATA;
                    bit_nx_s   = (bit_r == 3'd7) ? 3'd0 : bit_r + 3'd1;
                end
                S_ACK2: begin
                    state_nx_s = S_STOP;
                    bit_nx_s   = 3'd0;
                end
                // Slot 0 is the STOP waveform; slots 1-2 are bus-free time.
                S_STOP: begin
                    state_nx_s = (bit_r == 3'd2) ? S_DONE : S_STOP;
                    bit_nx_s   = (bit_r == 3'd2) ? 3'd0 : bit_r + 3'd1;
                end
                default: begin
                    state_nx_s = S_IDLE;
                    bit_nx_s   = 3'd0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Pin levels for the next position, registered below so they never glitch.
    always_comb begin
        tx_byte_s = (state_nx_s == S_ADDR) ? {addr_r, 1'b0} : data_r;
        scl_nx_s  = 1'b1;
        sda_nx_s  = 1'b0;
        case (state_nx_s)
            S_START: begin
                scl_nx_s = 1'b1;
                sda_nx_s = q_nx_s[1];
            end
            S_ADDR, S_DATA: begin
                scl_nx_s = q_nx_s[1];
                sda_nx_s = ~tx_byte_s[3'd7 - bit_nx_s];
            end
            S_ACK1, S_ACK2: begin
                scl_nx_s = q_nx_s[1];
                sda_nx_s = 1'b0;
            end
            S_STOP: begin
                if (bit_nx_s == 3'd0) begin
                    scl_nx_s = q_nx_s[1];
                    sda_nx_s = (q_nx_s != 2'd3);
                end else begin
                    scl_nx_s = 1'b1;
                    sda_nx_s = 1'b0;
                end
            end
            default: begin
                scl_nx_s = 1'b1;
                sda_nx_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, latched request and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_IDLE;
            div_r   <= {DW{1'b0}};
            q_r     <= 2'd0;
            bit_r   <= 3'd0;
            addr_r  <= 7'd0;
            data_r  <= 8'd0;
            sel_r   <= 1'b0;
            last_r  <= 1'b1;
            flag_r  <= 1'b0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
            scl     <= 1'b1;
            sda_oe  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            div_r   <= div_nx_s;
            q_r     <= q_nx_s;
            bit_r   <= bit_nx_s;
            scl     <= scl_nx_s;
            sda_oe  <= sda_nx_s;
            done    <= (state_nx_s == S_DONE);
            nack    <= (state_nx_s == S_DONE) & flag_r;
            case (state_r)
                S_IDLE: begin
                    if (any_req_s) begin
                        gnt    <= win1_s ? 2'b10 : 2'b01;
                        busy   <= 1'b1;
                        sel_r  <= win1_s;
                        addr_r <= win1_s ? addr1 : addr0;
                        data_r <= win1_s ? data1 : data0;
                        flag_r <= 1'b0;
                    end
                end
                S_ACK1, S_ACK2: begin
                    if ((q_r == 2'd2) && tick_s) begin
                        flag_r <= flag_r | sda_in;
                    end
                end
                S_DONE: begin
                    gnt    <= 2'b00;
                    busy   <= 1'b0;
                    last_r <= sel_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
